// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage. Owns the PC, feeds IF/ID and inserts
//               NOP bubbles for branches, jumps, multicycle mul and stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned J_HOLD   = 1,
    parameter int unsigned MUL_HOLD = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic [31:0] inst_i,
    input  logic        br_valid_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_incr_o,
    output logic [31:0] inst_o,
    output logic        busy_o
);

    localparam logic [5:0] c_j_cnt   = 6'(J_HOLD);
    localparam logic [5:0] c_mul_cnt = 6'(MUL_HOLD);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_HOLD_BR  = 2'd1,
        S_HOLD_J   = 2'd2,
        S_HOLD_MUL = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;
    logic [31:0] w_pc_incr;
    logic [5:0]  w_op;
    logic        w_is_br;
    logic        w_is_j;
    logic        w_is_mul;
    logic        w_fwd;

    assign w_op      = inst_i[31:26];
    assign w_is_br   = (w_op == 6'd4) || (w_op == 6'd5);
    assign w_is_j    = (w_op == 6'd2);
    assign w_is_mul  = (w_op == 6'd0) && (inst_i[5:0] == 6'd25);
    assign w_pc_incr = r_pc + 32'd4;

    // The fetched word only reaches IF/ID when the stage is genuinely issuing.
    assign w_fwd     = !rst && (r_state == S_RUN) && !stall_i;

    assign pc_o      = r_pc;
    assign pc_incr_o = w_pc_incr;
    assign inst_o    = w_fwd ? inst_i : 32'h0;
    assign busy_o    = (r_state != S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_state <= S_RUN;
            r_cnt   <= 6'd0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_pc_nxt    = r_pc;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (!stall_i) begin
                    w_pc_nxt = w_pc_incr;
                    if (w_is_br) begin
                        w_state_nxt = S_HOLD_BR;
                    end else if (w_is_j) begin
                        w_pc_nxt    = {w_pc_incr[31:28], inst_i[25:0], 2'b00};
                        w_cnt_nxt   = c_j_cnt;
                        w_state_nxt = S_HOLD_J;
                    end else if (w_is_mul) begin
                        w_cnt_nxt   = c_mul_cnt;
                        w_state_nxt = S_HOLD_MUL;
                    end
                end
            end
            S_HOLD_BR: begin
                // Not-taken needs no PC update: it already points at the fall-through.
                if (br_valid_i) begin
                    w_state_nxt = S_RUN;
                    if (br_taken_i) begin
                        w_pc_nxt = br_target_i;
                    end
                end
            end
            S_HOLD_J, S_HOLD_MUL: begin
                w_cnt_nxt = r_cnt - 6'd1;
                if (r_cnt == 6'd1) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Scoreboard testbench for if_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] c_beq = 32'h1022_0000;
    localparam logic [31:0] c_bne = 32'h1422_0000;
    localparam logic [31:0] c_mul = 32'h0022_1819;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        br_valid_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_target_i = 32'h0;
    logic [31:0] inst_i;
    logic [31:0] pc_o;
    logic [31:0] pc_incr_o;
    logic [31:0] inst_o;
    logic        busy_o;

    logic [31:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        st;
        logic        bv;
        logic        bt;
        logic [31:0] tg;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        busy;
    } cyc_t;

    cyc_t sb[$];
    cyc_t c;

    always #5 clk = ~clk;

    assign inst_i = mem[pc_o[9:2]];

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .J_HOLD   (1),
        .MUL_HOLD (33)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .inst_i      (inst_i),
        .br_valid_i  (br_valid_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .pc_o        (pc_o),
        .pc_incr_o   (pc_incr_o),
        .inst_o      (inst_o),
        .busy_o      (busy_o)
    );

    function automatic logic [31:0] aw(input logic [31:0] a);
        return {6'd0, 12'd0, a[9:2], 6'h20};
    endfunction

    function automatic logic [31:0] jw(input logic [25:0] idx);
        return {6'd2, idx};
    endfunction

    task automatic push(input logic st, input logic bv, input logic bt, input logic [31:0] tg,
                        input logic [31:0] pc, input logic [31:0] inst, input logic busy);
        cyc_t e;
        e.st = st; e.bv = bv; e.bt = bt; e.tg = tg;
        e.pc = pc; e.inst = inst; e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic push_run(input logic [31:0] pc);
        push(1'b0, 1'b0, 1'b0, 32'h0, pc, aw(pc), 1'b0);
    endtask

    task automatic push_bub(input logic [31:0] pc);
        push(1'b0, 1'b0, 1'b0, 32'h0, pc, 32'h0, 1'b1);
    endtask

    task automatic fill_mem;
        for (int i = 0; i < 256; i++) mem[i] = aw(32'(i) << 2);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; stall_i = 1'b0; br_valid_i = 1'b0; br_taken_i = 1'b0; br_target_i = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        fill_mem();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (pc_o !== 32'h0 || pc_incr_o !== 32'h4 || inst_o !== 32'h0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL reset: pc=%h incr=%h inst=%h busy=%b, expected pc=0 incr=4 inst=0 busy=0", pc_o, pc_incr_o, inst_o, busy_o);
            end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential;
        fill_mem();
        do_reset();
        push_run(32'h0); push_run(32'h4); push_run(32'h8); push_run(32'hC);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            stall_i = c.st; br_valid_i = c.bv; br_taken_i = c.bt; br_target_i = c.tg;
            #1; checks++;
            if (pc_o !== c.pc || pc_incr_o !== c.pc + 32'd4 || inst_o !== c.inst || busy_o !== c.busy) begin
                errors++;
                $display("FAIL sequential: pc=%h incr=%h inst=%h busy=%b, expected pc=%h inst=%h busy=%b", pc_o, pc_incr_o, inst_o, busy_o, c.pc, c.inst, c.busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_taken;
        fill_mem();
        mem[2] = c_beq;
        do_reset();
        push_run(32'h0);
        push(1'b0, 1'b1, 1'b1, 32'h80, 32'h4, aw(32'h4), 1'b0);
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'h8, c_beq, 1'b0);
        push_bub(32'hC); push_bub(32'hC);
        push(1'b0, 1'b1, 1'b1, 32'h40, 32'hC, 32'h0, 1'b1);
        push_run(32'h40); push_run(32'h44);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            stall_i = c.st; br_valid_i = c.bv; br_taken_i = c.bt; br_target_i = c.tg;
            #1; checks++;
            if (pc_o !== c.pc || pc_incr_o !== c.pc + 32'd4 || inst_o !== c.inst || busy_o !== c.busy) begin
                errors++;
                $display("FAIL branch_taken: pc=%h incr=%h inst=%h busy=%b, expected pc=%h inst=%h busy=%b", pc_o, pc_incr_o, inst_o, busy_o, c.pc, c.inst, c.busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_not_taken;
        fill_mem();
        mem[2] = c_bne;
        do_reset();
        push_run(32'h0); push_run(32'h4);
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'h8, c_bne, 1'b0);
        push(1'b1, 1'b0, 1'b0, 32'h0, 32'hC, 32'h0, 1'b1);
        push_bub(32'hC);
        push(1'b0, 1'b1, 1'b0, 32'h80, 32'hC, 32'h0, 1'b1);
        push_run(32'hC); push_run(32'h10);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            stall_i = c.st; br_valid_i = c.bv; br_taken_i = c.bt; br_target_i = c.tg;
            #1; checks++;
            if (pc_o !== c.pc || pc_incr_o !== c.pc + 32'd4 || inst_o !== c.inst || busy_o !== c.busy) begin
                errors++;
                $display("FAIL branch_not_taken: pc=%h incr=%h inst=%h busy=%b, expected pc=%h inst=%h busy=%b", pc_o, pc_incr_o, inst_o, busy_o, c.pc, c.inst, c.busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jump;
        fill_mem();
        mem[4] = jw(26'h100);
        do_reset();
        push_run(32'h0); push_run(32'h4); push_run(32'h8); push_run(32'hC);
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'h10, jw(26'h100), 1'b0);
        push_bub(32'h400);
        push_run(32'h400); push_run(32'h404);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            stall_i = c.st; br_valid_i = c.bv; br_taken_i = c.bt; br_target_i = c.tg;
            #1; checks++;
            if (pc_o !== c.pc || pc_incr_o !== c.pc + 32'd4 || inst_o !== c.inst || busy_o !== c.busy) begin
                errors++;
                $display("FAIL jump: pc=%h incr=%h inst=%h busy=%b, expected pc=%h inst=%h busy=%b", pc_o, pc_incr_o, inst_o, busy_o, c.pc, c.inst, c.busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mul;
        fill_mem();
        mem[0] = c_mul;
        do_reset();
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c_mul, 1'b0);
        for (int i = 0; i < 33; i++) begin
            push((i == 10 || i == 11 || i == 32), 1'b0, 1'b0, 32'h0, 32'h4, 32'h0, 1'b1);
        end
        push_run(32'h4); push_run(32'h8);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            stall_i = c.st; br_valid_i = c.bv; br_taken_i = c.bt; br_target_i = c.tg;
            #1; checks++;
            if (pc_o !== c.pc || pc_incr_o !== c.pc + 32'd4 || inst_o !== c.inst || busy_o !== c.busy) begin
                errors++;
                $display("FAIL mul_hold: pc=%h incr=%h inst=%h busy=%b, expected pc=%h inst=%h busy=%b", pc_o, pc_incr_o, inst_o, busy_o, c.pc, c.inst, c.busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall;
        fill_mem();
        do_reset();
        for (int i = 0; i < 8; i++) push_run(32'(i) << 2);
        push(1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 32'h0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 32'h0, 1'b0);
        push_run(32'h20); push_run(32'h24);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            stall_i = c.st; br_valid_i = c.bv; br_taken_i = c.bt; br_target_i = c.tg;
            #1; checks++;
            if (pc_o !== c.pc || pc_incr_o !== c.pc + 32'd4 || inst_o !== c.inst || busy_o !== c.busy) begin
                errors++;
                $display("FAIL stall: pc=%h incr=%h inst=%h busy=%b, expected pc=%h inst=%h busy=%b", pc_o, pc_incr_o, inst_o, busy_o, c.pc, c.inst, c.busy);
            end
            @(negedge clk);
        end
        stall_i = 1'b0;
    endtask

    task automatic test_reset_mid_mul;
        fill_mem();
        mem[0] = c_mul;
        do_reset();
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c_mul, 1'b0);
        for (int i = 0; i < 5; i++) push_bub(32'h4);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            stall_i = c.st; br_valid_i = c.bv; br_taken_i = c.bt; br_target_i = c.tg;
            #1; checks++;
            if (pc_o !== c.pc || pc_incr_o !== c.pc + 32'd4 || inst_o !== c.inst || busy_o !== c.busy) begin
                errors++;
                $display("FAIL pre_reset_mul: pc=%h incr=%h inst=%h busy=%b, expected pc=%h inst=%h busy=%b", pc_o, pc_incr_o, inst_o, busy_o, c.pc, c.inst, c.busy);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        #1; checks++;
        if (pc_o !== 32'h0 || pc_incr_o !== 32'h4 || inst_o !== 32'h0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pc=%h incr=%h inst=%h busy=%b, expected pc=0 incr=4 inst=0 busy=0", pc_o, pc_incr_o, inst_o, busy_o);
        end
        @(negedge clk);
        rst = 1'b0;
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c_mul, 1'b0);
        push_bub(32'h4);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            stall_i = c.st; br_valid_i = c.bv; br_taken_i = c.bt; br_target_i = c.tg;
            #1; checks++;
            if (pc_o !== c.pc || pc_incr_o !== c.pc + 32'd4 || inst_o !== c.inst || busy_o !== c.busy) begin
                errors++;
                $display("FAIL post_reset_mul: pc=%h incr=%h inst=%h busy=%b, expected pc=%h inst=%h busy=%b", pc_o, pc_incr_o, inst_o, busy_o, c.pc, c.inst, c.busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap;
        fill_mem();
        mem[2]   = c_beq;
        mem[255] = jw(26'h100);
        do_reset();
        push_run(32'h0); push_run(32'h4);
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'h8, c_beq, 1'b0);
        push(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'hC, 32'h0, 1'b1);
        push_run(32'hFFFF_FFF8);
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, jw(26'h100), 1'b0);
        push_bub(32'h400);
        push_run(32'h400);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            stall_i = c.st; br_valid_i = c.bv; br_taken_i = c.bt; br_target_i = c.tg;
            #1; checks++;
            if (pc_o !== c.pc || pc_incr_o !== c.pc + 32'd4 || inst_o !== c.inst || busy_o !== c.busy) begin
                errors++;
                $display("FAIL wrap: pc=%h incr=%h inst=%h busy=%b, expected pc=%h inst=%h busy=%b", pc_o, pc_incr_o, inst_o, busy_o, c.pc, c.inst, c.busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        fill_mem();
        mem[0] = jw(26'h2);
        mem[2] = jw(26'h4);
        mem[4] = c_beq;
        do_reset();
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, jw(26'h2), 1'b0);
        push_bub(32'h8);
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'h8, jw(26'h4), 1'b0);
        push_bub(32'h10);
        push(1'b0, 1'b0, 1'b0, 32'h0, 32'h10, c_beq, 1'b0);
        push(1'b0, 1'b1, 1'b1, 32'h20, 32'h14, 32'h0, 1'b1);
        push_run(32'h20);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            stall_i = c.st; br_valid_i = c.bv; br_taken_i = c.bt; br_target_i = c.tg;
            #1; checks++;
            if (pc_o !== c.pc || pc_incr_o !== c.pc + 32'd4 || inst_o !== c.inst || busy_o !== c.busy) begin
                errors++;
                $display("FAIL back_to_back: pc=%h incr=%h inst=%h busy=%b, expected pc=%h inst=%h busy=%b", pc_o, pc_incr_o, inst_o, busy_o, c.pc, c.inst, c.busy);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_taken();
        test_branch_not_taken();
        test_jump();
        test_mul();
        test_stall();
        test_reset_mid_mul();
        test_wrap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
